serial_remainder_mod_n: RTL and testbench



---
 rtl/serial_remainder_mod_n.sv | 93 +++++++++
 tb/tb_serial_remainder_mod_n.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_remainder_mod_n.sv
// MSB-first serial remainder tracker for a runtime-selected divisor in 1..MAX_DIVISOR.
// Each accepted bit updates remainder = (2*remainder + bit) mod divisor using one conditional subtract.
module serial_remainder_mod_n #(
    parameter int MAX_DIVISOR = 15,
    parameter int DW          = $clog2(MAX_DIVISOR + 1),
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    divisor_in,
    input  logic             bit_valid,
    input  logic             new_bit,
    output logic             active,
    output logic             error,
    output logic [DW-1:0]    remainder,
    output logic             div_by_n,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [DW:0] MAX_D = (DW + 1)'(MAX_DIVISOR);

    state_t           state_reg, state_next;
    logic [DW-1:0]    divisor_reg;
    logic [DW-1:0]    rem_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             div_legal;
    logic [DW-1:0]    base_rem;
    logic [DW:0]      dsel_ext;
    logic [DW:0]      t_ext;
    logic [DW-1:0]    rem_step;

    assign div_legal = (divisor_in != '0) && ({1'b0, divisor_in} <= MAX_D);

    // A start cycle folds its bit into an empty number under the new divisor.
    assign base_rem = start ? '0 : rem_reg;
    assign dsel_ext = start ? {1'b0, divisor_in} : {1'b0, divisor_reg};
    assign t_ext    = {base_rem, new_bit};
    assign rem_step = DW'((t_ext >= dsel_ext) ? (t_ext - dsel_ext) : t_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = div_legal ? RUN : ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor_reg <= '0;
            rem_reg     <= '0;
            cnt_reg     <= '0;
        end else if (start) begin
            if (div_legal) begin
                divisor_reg <= divisor_in;
                rem_reg     <= bit_valid ? rem_step : '0;
                cnt_reg     <= bit_valid ? CNT_W'(1) : '0;
            end else begin
                rem_reg <= '0;
                cnt_reg <= '0;
            end
        end else if (state_reg == RUN && bit_valid) begin
            rem_reg <= rem_step;
            if (cnt_reg != '1) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        active    = (state_reg == RUN);
        error     = (state_reg == ERR);
        remainder = (state_reg == RUN) ? rem_reg : '0;
        div_by_n  = (state_reg == RUN) && (rem_reg == '0);
        bit_count = cnt_reg;
    end

endmodule

// File: tb/tb_serial_remainder_mod_n.sv
// Bench for serial_remainder_mod_n: directed scenarios plus random numbers, checked
// against a model that tracks the whole number as an integer and takes value % divisor.
module tb_serial_remainder_mod_n;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] divisor_in = '0;
    logic          bit_valid = 1'b0;
    logic          new_bit = 1'b0;

    logic          active, error, div_by_n;
    logic [DW-1:0] remainder;
    logic [7:0]    bit_count;

    logic          active3, error3, div_by_n3;
    logic [DW-1:0] remainder3;
    logic [2:0]    bit_count3;

    int n_vec  = 0;
    int n_fail = 0;

    // model: mode 0=idle 1=run 2=err
    int     m_mode = 0;
    int     m_div  = 0;
    longint m_value = 0;
    int     m_len  = 0;

    always #5 clk = ~clk;

    serial_remainder_mod_n #(.MAX_DIVISOR(15), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .divisor_in(divisor_in),
        .bit_valid(bit_valid), .new_bit(new_bit),
        .active(active), .error(error), .remainder(remainder),
        .div_by_n(div_by_n), .bit_count(bit_count)
    );

    serial_remainder_mod_n #(.MAX_DIVISOR(15), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .divisor_in(divisor_in),
        .bit_valid(bit_valid), .new_bit(new_bit),
        .active(active3), .error(error3), .remainder(remainder3),
        .div_by_n(div_by_n3), .bit_count(bit_count3)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_apply(input bit r, input bit s, input int d, input bit v, input bit b);
        if (r) begin
            m_mode = 0; m_value = 0; m_len = 0;
        end else if (s) begin
            if (d == 0 || d > 15) begin
                m_mode = 2;
            end else begin
                m_mode = 1; m_div = d; m_value = 0; m_len = 0;
                if (v) begin
                    m_value = longint'(b); m_len = 1;
                end
            end
        end else if (m_mode == 1 && v) begin
            m_value = m_value * 2 + longint'(b);
            m_len++;
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic cyc(input bit r, input bit s, input int d, input bit v, input bit b);
        int exp_rem;
        rst = r; start = s; divisor_in = DW'(d); bit_valid = v; new_bit = b;
        @(posedge clk);
        model_apply(r, s, d, v, b);
        #1;
        exp_rem = (m_mode == 1) ? int'(m_value % longint'(m_div)) : 0;
        check("active", int'(active), int'(m_mode == 1));
        check("error", int'(error), int'(m_mode == 2));
        check("remainder", int'(remainder), exp_rem);
        check("div_by_n", int'(div_by_n), int'(m_mode == 1 && exp_rem == 0));
        check("remainder_c3", int'(remainder3), exp_rem);
        check("div_by_n_c3", int'(div_by_n3), int'(m_mode == 1 && exp_rem == 0));
        if (m_mode != 2) begin
            check("bit_count", int'(bit_count), (m_len > 255) ? 255 : m_len);
            check("bit_count_c3", int'(bit_count3), (m_len > 7) ? 7 : m_len);
        end
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
    endtask

    initial begin
        int exp1[4];
        int exp2[8];
        int d;
        int len;
        exp1 = '{1, 2, 0, 0};
        exp2 = '{1, 3, 7, 0, 1, 3, 7, 0};

        // reset
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("reset_rem", int'(remainder), 0);
        check("reset_cnt", int'(bit_count), 0);

        // divisor 5, bits 1,0,1,0
        cyc(0, 1, 5, 0, 0);
        check("empty_div_by_n", int'(div_by_n), 1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, (i % 2) == 0);
            check("t1_rem", int'(remainder), exp1[i]);
            check("t1_cnt", int'(bit_count), i + 1);
        end

        // divisor 15, 255 with gaps
        cyc(0, 1, 15, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 1);
            check("t2_rem", int'(remainder), exp2[i]);
            cyc(0, 0, 0, 0, 0);
            check("t2_hold", int'(remainder), exp2[i]);
        end
        check("t2_div", int'(div_by_n), 1);
        check("t2_cnt", int'(bit_count), 8);

        // illegal divisors 0 and 16, then recover with 3
        cyc(0, 1, 0, 0, 0);
        check("t3_err0", int'(error), 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 16, 0, 0);
        check("t3_err16", int'(error), 1);
        check("t3_act16", int'(active), 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 3, 0, 0);
        check("t3_recover", int'(active), 1);
        check("t3_rem", int'(remainder), 0);

        // divisor 7, bits 1,1, then start 3 with a bit in the same cycle
        cyc(0, 1, 7, 0, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        check("t4_rem7", int'(remainder), 3);
        cyc(0, 1, 3, 1, 1);
        check("t4_rem", int'(remainder), 1);
        check("t4_cnt", int'(bit_count), 1);
        cyc(0, 0, 0, 1, 1);
        check("t4_div", int'(div_by_n), 1);

        // divisor 13, bits 1,1,0, reset mid-number, bits in IDLE ignored
        cyc(0, 1, 13, 0, 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);
        check("t5_rem", int'(remainder), 6);
        cyc(1, 0, 0, 1, 1);
        check("t5_idle", int'(active), 0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        check("t5_idle_cnt", int'(bit_count), 0);

        // divisor 1, ten bits: narrow counter saturates
        cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 1, 1'($urandom_range(0, 1)));
        end
        check("t6_sat3", int'(bit_count3), 7);
        check("t6_cnt8", int'(bit_count), 10);

        // random numbers with random gaps, illegal divisors and resets
        for (int n = 0; n < 60; n++) begin
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) * 16 % 17 : int'($urandom_range(1, 15));
            cyc($urandom_range(0, 19) == 0, 1, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            len = $urandom_range(0, 50);
            for (int i = 0; i < len; i++) begin
                cyc(0, 0, 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            end
        end
        // long number past 8-bit counter saturation (value kept under 60 bits)
        cyc(0, 1, 11, 1, 1);
        for (int i = 0; i < 270; i++) begin
            cyc(0, 0, 0, 1, (i < 50) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (i >= 55) begin
                m_value = m_value % longint'(m_div);
            end
        end
        check("sat_cnt8", int'(bit_count), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
